// File: rtl/control_pkg.sv
// Shared encodings, opcode/funct constants and control-word field offsets for the MIPS main decoder.
package control_pkg;

  localparam int unsigned CW_W  = 20;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 4;

  // control_word field offsets
  localparam int unsigned REG_WRITE_BIT    = 19;
  localparam int unsigned REG_DST_LSB      = 17;
  localparam int unsigned ALU_SRC_BIT      = 16;
  localparam int unsigned EXT_OP_LSB       = 14;
  localparam int unsigned ALU_CTRL_LSB     = 10;
  localparam int unsigned MEM_READ_BIT     = 9;
  localparam int unsigned MEM_WRITE_BIT    = 8;
  localparam int unsigned MEM_SIZE_LSB     = 6;
  localparam int unsigned MEM_UNSIGNED_BIT = 5;
  localparam int unsigned WB_SEL_LSB       = 3;
  localparam int unsigned PC_SEL_LSB       = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                              OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                              OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                              OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
                              OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH    = 6'h21,
                              OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU   = 6'h25,
                              OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                              FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                              FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                              FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                              FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                              FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2, ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4, ALU_NOR  = 4'h5, ALU_SLT  = 4'h6, ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8, ALU_SRL  = 4'h9, ALU_SRA  = 4'hA, ALU_SLLV = 4'hB,
    ALU_SRLV = 4'hC, ALU_SRAV = 4'hD, ALU_PASSB = 4'hE
  } alu_ctrl_e;

  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_op_e;
  typedef enum logic [1:0] {SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10} mem_size_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_e;
  typedef enum logic [2:0] {
    PC_PLUS4 = 3'b000, PC_BEQ = 3'b001, PC_BNE = 3'b010, PC_JUMP = 3'b011, PC_REG = 3'b100
  } pc_sel_e;

  // Assemble the control word from its individual fields
  function automatic logic [CW_W-1:0] pack_cw(
    input logic rw, input reg_dst_e dst, input logic asrc, input ext_op_e ext,
    input alu_ctrl_e alu, input logic mr, input logic mw, input mem_size_e sz,
    input logic mu, input wb_sel_e wb, input pc_sel_e pc);
    logic [CW_W-1:0] w;
    w = '0;
    w[REG_WRITE_BIT]        = rw;
    w[REG_DST_LSB +: 2]     = dst;
    w[ALU_SRC_BIT]          = asrc;
    w[EXT_OP_LSB +: 2]      = ext;
    w[ALU_CTRL_LSB +: ALU_W] = alu;
    w[MEM_READ_BIT]         = mr;
    w[MEM_WRITE_BIT]        = mw;
    w[MEM_SIZE_LSB +: 2]    = sz;
    w[MEM_UNSIGNED_BIT]     = mu;
    w[WB_SEL_LSB +: 2]      = wb;
    w[PC_SEL_LSB +: 3]      = pc;
    return w;
  endfunction

endpackage

// File: rtl/funct_decoder.sv
// R-type funct field decoder: produces the register/ALU/next-PC fields for opcode 0.
module funct_decoder
  import control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl_c,
  output logic [1:0] reg_dst_c,
  output logic [1:0] wb_sel_c,
  output logic [2:0] pc_sel_c,
  output logic       reg_write_c,
  output logic       valid_c
);

  always_comb begin
    alu_ctrl_c  = ALU_ADD;
    reg_dst_c   = DST_RD;
    wb_sel_c    = WB_ALU;
    pc_sel_c    = PC_PLUS4;
    reg_write_c = 1'b1;
    valid_c     = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: alu_ctrl_c = ALU_ADD;
      FN_SUB, FN_SUBU: alu_ctrl_c = ALU_SUB;
      FN_AND:  alu_ctrl_c = ALU_AND;
      FN_OR:   alu_ctrl_c = ALU_OR;
      FN_XOR:  alu_ctrl_c = ALU_XOR;
      FN_NOR:  alu_ctrl_c = ALU_NOR;
      FN_SLT:  alu_ctrl_c = ALU_SLT;
      FN_SLTU: alu_ctrl_c = ALU_SLTU;
      FN_SLL:  alu_ctrl_c = ALU_SLL;
      FN_SRL:  alu_ctrl_c = ALU_SRL;
      FN_SRA:  alu_ctrl_c = ALU_SRA;
      FN_SLLV: alu_ctrl_c = ALU_SLLV;
      FN_SRLV: alu_ctrl_c = ALU_SRLV;
      FN_SRAV: alu_ctrl_c = ALU_SRAV;
      FN_JR: begin
        reg_write_c = 1'b0;
        reg_dst_c   = DST_RT;
        pc_sel_c    = PC_REG;
      end
      FN_JALR: begin
        wb_sel_c = WB_PC4;
        pc_sel_c = PC_REG;
      end
      default: begin
        reg_write_c = 1'b0;
        reg_dst_c   = DST_RT;
        valid_c     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle MIPS main decoder with sticky illegal-instruction flag.
// Define CONTROL_UNIT_REG_OUT_EN to register control_word and illegal (one cycle latency).
module control_unit
  import control_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [CW_W-1:0]  control_word,
  output logic             illegal,
  output logic             illegal_seen
);

  logic [3:0] r_alu;
  logic [1:0] r_dst;
  logic [1:0] r_wb;
  logic [2:0] r_pc;
  logic       r_rw;
  logic       r_valid;

  logic      rw, asrc, mr, mw, mu, ill_c;
  reg_dst_e  dst;
  ext_op_e   ext;
  alu_ctrl_e alu;
  mem_size_e sz;
  wb_sel_e   wb;
  pc_sel_e   pc;
  logic [CW_W-1:0] cw_c;

  funct_decoder u_funct_decoder (
    .funct       (funct),
    .alu_ctrl_c  (r_alu),
    .reg_dst_c   (r_dst),
    .wb_sel_c    (r_wb),
    .pc_sel_c    (r_pc),
    .reg_write_c (r_rw),
    .valid_c     (r_valid)
  );

  // Opcode decode; all-zero defaults double as the illegal-encoding word
  always_comb begin
    rw = 1'b0; dst = DST_RT; asrc = 1'b0; ext = EXT_ZERO; alu = ALU_ADD;
    mr = 1'b0; mw = 1'b0; sz = SIZE_WORD; mu = 1'b0; wb = WB_ALU; pc = PC_PLUS4;
    ill_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (r_valid) begin
          rw  = r_rw;
          dst = reg_dst_e'(r_dst);
          alu = alu_ctrl_e'(r_alu);
          wb  = wb_sel_e'(r_wb);
          pc  = pc_sel_e'(r_pc);
        end else begin
          ill_c = 1'b1;
        end
      end
      OP_J:   pc = PC_JUMP;
      OP_JAL: begin rw = 1'b1; dst = DST_RA; wb = WB_PC4; pc = PC_JUMP; end
      OP_BEQ: begin ext = EXT_SIGN; alu = ALU_SUB; pc = PC_BEQ; end
      OP_BNE: begin ext = EXT_SIGN; alu = ALU_SUB; pc = PC_BNE; end
      OP_ADDI, OP_ADDIU: begin rw = 1'b1; asrc = 1'b1; ext = EXT_SIGN; end
      OP_SLTI:  begin rw = 1'b1; asrc = 1'b1; ext = EXT_SIGN; alu = ALU_SLT; end
      OP_SLTIU: begin rw = 1'b1; asrc = 1'b1; ext = EXT_SIGN; alu = ALU_SLTU; end
      OP_ANDI:  begin rw = 1'b1; asrc = 1'b1; alu = ALU_AND; end
      OP_ORI:   begin rw = 1'b1; asrc = 1'b1; alu = ALU_OR; end
      OP_XORI:  begin rw = 1'b1; asrc = 1'b1; alu = ALU_XOR; end
      OP_LUI:   begin rw = 1'b1; asrc = 1'b1; ext = EXT_LUI; alu = ALU_PASSB; end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        rw = 1'b1; asrc = 1'b1; ext = EXT_SIGN; mr = 1'b1; wb = WB_MEM;
        if (opcode == OP_LH || opcode == OP_LHU) sz = SIZE_HALF;
        if (opcode == OP_LB || opcode == OP_LBU) sz = SIZE_BYTE;
        mu = (opcode == OP_LHU) || (opcode == OP_LBU);
      end
      OP_SW: begin asrc = 1'b1; ext = EXT_SIGN; mw = 1'b1; end
      OP_SH: begin asrc = 1'b1; ext = EXT_SIGN; mw = 1'b1; sz = SIZE_HALF; end
      OP_SB: begin asrc = 1'b1; ext = EXT_SIGN; mw = 1'b1; sz = SIZE_BYTE; end
      default: ill_c = 1'b1;
    endcase
    cw_c = pack_cw(rw, dst, asrc, ext, alu, mr, mw, sz, mu, wb, pc);
  end

`ifdef CONTROL_UNIT_REG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_word <= '0;
      illegal      <= 1'b0;
    end else begin
      control_word <= cw_c;
      illegal      <= ill_c;
    end
  end
`else
  assign control_word = cw_c;
  assign illegal      = ill_c;
`endif

  // Sticky illegal-instruction status, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_seen <= 1'b0;
    else if (illegal) illegal_seen <= 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: table-driven reference decode, random plus directed stimulus.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [19:0] control_word;
  logic        illegal, illegal_seen;

  always #5 clk = ~clk;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct        (funct),
    .control_word (control_word),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

`ifdef CONTROL_UNIT_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  typedef struct {
    logic [19:0] word;
    logic        ill;
    logic        seen;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [19:0] r_tab[int];
  logic [19:0] i_tab[int];
  logic        m_seen, m_prev_ill;
  logic [5:0]  op_list[21];
  logic [5:0]  fn_list[18];

  // Expected control words, written out per instruction from the field table
  task automatic fill_tables();
    r_tab[32'h20] = 20'hA0000; r_tab[32'h21] = 20'hA0000;
    r_tab[32'h22] = 20'hA0400; r_tab[32'h23] = 20'hA0400;
    r_tab[32'h24] = 20'hA0800; r_tab[32'h25] = 20'hA0C00;
    r_tab[32'h26] = 20'hA1000; r_tab[32'h27] = 20'hA1400;
    r_tab[32'h2A] = 20'hA1800; r_tab[32'h2B] = 20'hA1C00;
    r_tab[32'h00] = 20'hA2000; r_tab[32'h02] = 20'hA2400;
    r_tab[32'h03] = 20'hA2800; r_tab[32'h04] = 20'hA2C00;
    r_tab[32'h06] = 20'hA3000; r_tab[32'h07] = 20'hA3400;
    r_tab[32'h08] = 20'h00004; r_tab[32'h09] = 20'hA0014;
    i_tab[32'h02] = 20'h00003; i_tab[32'h03] = 20'hC0013;
    i_tab[32'h04] = 20'h04401; i_tab[32'h05] = 20'h04402;
    i_tab[32'h08] = 20'h94000; i_tab[32'h09] = 20'h94000;
    i_tab[32'h0A] = 20'h95800; i_tab[32'h0B] = 20'h95C00;
    i_tab[32'h0C] = 20'h90800; i_tab[32'h0D] = 20'h90C00;
    i_tab[32'h0E] = 20'h91000; i_tab[32'h0F] = 20'h9B800;
    i_tab[32'h23] = 20'h94208; i_tab[32'h21] = 20'h94248;
    i_tab[32'h25] = 20'h94268; i_tab[32'h20] = 20'h94288;
    i_tab[32'h24] = 20'h942A8; i_tab[32'h2B] = 20'h14100;
    i_tab[32'h29] = 20'h14140; i_tab[32'h28] = 20'h14180;
    op_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    fn_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
                6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  endtask

  function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                output logic [19:0] w, output logic ill);
    w = 20'h0;
    ill = 1'b1;
    if (op == 6'h00) begin
      if (r_tab.exists(int'(fn))) begin w = r_tab[int'(fn)]; ill = 1'b0; end
    end else if (i_tab.exists(int'(op))) begin
      w = i_tab[int'(op)]; ill = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one encoding for a cycle and push what the outputs must show after the next edge
  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    logic [19:0] w;
    logic ill;
    @(negedge clk);
    opcode = op;
    funct  = fn;
    model(op, fn, w, ill);
    m_seen = m_seen | (REG_OUT ? m_prev_ill : ill);
    m_prev_ill = ill;
    e.word = w;
    e.ill  = ill;
    e.seen = m_seen;
    e.name = $sformatf("op%02h_fn%02h", op, fn);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: one result per clock edge once the queue holds an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, "_word"}, 32'(control_word), 32'(e.word));
        check({e.name, "_illegal"}, 32'(illegal), 32'(e.ill));
        check({e.name, "_seen"}, 32'(illegal_seen), 32'(e.seen));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    logic [19:0] w;
    logic ill;
    fill_tables();
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    m_seen = 1'b0;
    m_prev_ill = 1'b0;
    #2;
    check("reset_seen", 32'(illegal_seen), 32'd0);
    check("reset_word", 32'(control_word), REG_OUT ? 32'd0 : 32'hA0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    drive(6'h00, 6'h20);
    drive(6'h23, 6'h15);
    drive(6'h2B, 6'h3F);
    drive(6'h04, 6'h00);
    drive(6'h03, 6'h11);
    drive(6'h00, 6'h08);
    drive(6'h0F, 6'h2A);
    drive(6'h00, 6'h00);
    drive(6'h3F, 6'h00);
    drive(6'h00, 6'h20);
    drive(6'h00, 6'h01);
    drive(6'h25, 6'h00);
    drive(6'h00, 6'h20);
    drain();

    // Asynchronous reset in the middle of the low phase
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model(opcode, funct, w, ill);
    check("midreset_seen", 32'(illegal_seen), 32'd0);
    check("midreset_word", 32'(control_word), REG_OUT ? 32'd0 : 32'(w));
    check("midreset_illegal", 32'(illegal), REG_OUT ? 32'd0 : 32'(ill));
    sb_q.delete();
    m_seen = 1'b0;
    m_prev_ill = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : op_list[$urandom_range(0, 20)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fn_list[$urandom_range(0, 17)];
      drive(op, fn);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
